// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
//   Shared types for the up/down modulus counter family.
//   mode_t  : counting behaviour at the range boundary
//             MODE_WRAP    - roll over modulo (MAX_VAL+1), pulse tc on roll-over
//             MODE_SAT     - clamp at the limit, pulse tc once when it is reached
//             MODE_ONESHOT - clamp at the limit, pulse tc and freeze (done)
//             MODE_RSVD    - reserved, behaves as MODE_WRAP
//   state_t : one-shot control FSM (ST_ARMED counting, ST_DONE frozen)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_t;

  typedef enum logic {
    ST_ARMED = 1'b0,
    ST_DONE  = 1'b1
  } state_t;

endpackage : counter_pkg

// File: rtl/counter_prescaler.sv
// -----------------------------------------------------------------------------
// counter_prescaler
//   Divides enabled cycles by PRESCALE. The internal count advances 0..PRESCALE-1
//   on every cycle with enable=1 and freezes while enable=0. tick is high on the
//   enabled cycle in which the count sits at PRESCALE-1, so with PRESCALE=1 the
//   tick simply follows enable.
// Ports
//   clk     in  rising-edge clock
//   reset   in  asynchronous, active-low reset (count -> 0)
//   enable  in  advance the prescaler this cycle
//   clear   in  synchronous restart of the count at 0 (wins over enable)
//   tick    out count-tick request for the counter (combinational)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module counter_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] ONE  = PW'(1);

  logic [PW-1:0] pcnt_p1;

  // ---- stage p1: prescaler count register ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt_p1 <= '0;
    end else if (clear) begin
      pcnt_p1 <= '0;
    end else if (enable) begin
      pcnt_p1 <= (pcnt_p1 == LAST) ? '0 : pcnt_p1 + ONE;
    end
  end

  assign tick = enable && (pcnt_p1 == LAST);

endmodule : counter_prescaler

// File: rtl/updown_mod_counter.sv
// -----------------------------------------------------------------------------
// updown_mod_counter
//   Generic timer/event counter. Counts 0..MAX_VAL in steps of STEP, up or
//   down, once every PRESCALE enabled cycles. At the range boundary it wraps,
//   saturates or stops (one-shot) according to mode, and emits a one-cycle
//   terminal-count pulse aligned with the cycle that shows the boundary result.
// Parameters
//   WIDTH     counter width in bits
//   MAX_VAL   highest count value (< 2**WIDTH)
//   STEP      increment/decrement per tick (1..MAX_VAL)
//   PRESCALE  enabled cycles per tick (>= 1)
// Ports
//   clk     in   rising-edge clock
//   reset   in   asynchronous, active-low reset
//   d       in   parallel load value (clamped to MAX_VAL)
//   load    in   synchronous load, overrides counting and enable
//   enable  in   count enable (gates prescaler and counter)
//   up      in   direction, 1 = up, 0 = down
//   mode    in   00 wrap, 01 saturate, 10 one-shot, 11 wrap
//   out     out  current count (registered)
//   tc      out  terminal-count pulse (registered, one cycle)
//   done    out  one-shot finished, count frozen (registered)
// Priority on each edge: reset > load > count tick > hold.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module updown_mod_counter #(
  parameter int WIDTH    = 8,
  parameter int MAX_VAL  = 255,
  parameter int STEP     = 1,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  input  logic             load,
  input  logic             enable,
  input  logic             up,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             done
);

  import counter_pkg::*;

  // Parameter sanity, caught at elaboration.
  if (MAX_VAL < 0 || MAX_VAL > (2**WIDTH) - 1) begin : g_bad_max
    $error("updown_mod_counter: MAX_VAL must lie in 0..2**WIDTH-1");
  end
  if (STEP < 1 || STEP > MAX_VAL) begin : g_bad_step
    $error("updown_mod_counter: STEP must lie in 1..MAX_VAL");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("updown_mod_counter: PRESCALE must be at least 1");
  end

  // Up arithmetic is unsigned in WIDTH+1 bits; down arithmetic is signed in
  // WIDTH+2 bits so that the modulus (which can be 2**WIDTH) stays positive.
  localparam logic [WIDTH-1:0]        MAX_W  = WIDTH'(MAX_VAL);
  localparam logic [WIDTH:0]          MAX_U  = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0]          MOD_U  = (WIDTH+1)'(MAX_VAL + 1);
  localparam logic [WIDTH:0]          STEP_U = (WIDTH+1)'(STEP);
  localparam logic signed [WIDTH+1:0] MOD_S  = signed'((WIDTH+2)'(MAX_VAL + 1));
  localparam logic signed [WIDTH+1:0] STEP_S = signed'((WIDTH+2)'(STEP));

  typedef struct packed {
    logic [WIDTH-1:0] val;  // count after this tick
    logic             tc;   // terminal-count pulse for this tick
    logic             hit;  // one-shot limit reached -> freeze
  } step_t;

  // Boundary handling for one tick. In wrap mode tc marks a real roll-over
  // only; in saturate/one-shot an exact landing on the limit counts as
  // reaching it. Saturate pulses tc only on the tick that arrives at the
  // limit, never while already parked there.
  function automatic step_t next_count(input logic [WIDTH-1:0] cur,
                                       input logic             dir_up,
                                       input mode_t            m);
    step_t                   r;
    logic [WIDTH:0]          up_sum;
    logic signed [WIDTH+1:0] dn_diff;
    logic                    beyond;
    logic                    reached;
    logic [WIDTH-1:0]        lim;
    logic [WIDTH-1:0]        plain;
    logic [WIDTH-1:0]        wrapped;
    up_sum  = {1'b0, cur} + STEP_U;
    dn_diff = signed'({2'b00, cur}) - STEP_S;
    if (dir_up) begin
      beyond  = (up_sum > MAX_U);
      reached = (up_sum >= MAX_U);
      lim     = MAX_W;
      plain   = up_sum[WIDTH-1:0];
      wrapped = WIDTH'(up_sum - MOD_U);
    end else begin
      beyond  = dn_diff[WIDTH+1];
      reached = dn_diff[WIDTH+1] || (dn_diff == '0);
      lim     = '0;
      plain   = dn_diff[WIDTH-1:0];
      wrapped = WIDTH'(dn_diff + MOD_S);
    end
    r.val = plain;
    r.tc  = 1'b0;
    r.hit = 1'b0;
    case (m)
      MODE_SAT: begin
        if (reached) begin
          r.val = lim;
          r.tc  = (cur != lim);
        end
      end
      MODE_ONESHOT: begin
        if (reached) begin
          r.val = lim;
          r.tc  = 1'b1;
          r.hit = 1'b1;
        end
      end
      default: begin
        if (beyond) begin
          r.val = wrapped;
          r.tc  = 1'b1;
        end
      end
    endcase
    return r;
  endfunction

  // Load values above the range are pulled down to MAX_VAL.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    return (v > MAX_W) ? MAX_W : v;
  endfunction

  logic             tick_p0;
  mode_t            mode_p0;
  step_t            step_p0;
  logic [WIDTH-1:0] count_p1;
  logic             tc_p1;
  logic             done_p1;
  state_t           state_p1;

  counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .clear  (load),
    .tick   (tick_p0)
  );

  // ---- stage p0: next-count arithmetic from the current count ----
  assign mode_p0 = mode_t'(mode);
  assign step_p0 = next_count(count_p1, up, mode_p0);

  // ---- stage p1: count, tc and one-shot FSM registers ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_p1 <= '0;
      tc_p1    <= 1'b0;
      done_p1  <= 1'b0;
      state_p1 <= ST_ARMED;
    end else if (load) begin
      count_p1 <= clamp_load(d);
      tc_p1    <= 1'b0;
      done_p1  <= 1'b0;
      state_p1 <= ST_ARMED;
    end else begin
      tc_p1 <= 1'b0;
      if (enable) begin
        case (state_p1)
          ST_ARMED: begin
            if (tick_p0) begin
              count_p1 <= step_p0.val;
              tc_p1    <= step_p0.tc;
              if (step_p0.hit) begin
                state_p1 <= ST_DONE;
                done_p1  <= 1'b1;
              end
            end
          end
          ST_DONE: begin
            // Leaving one-shot re-arms; counting resumes on the next tick.
            if (mode_p0 != MODE_ONESHOT) begin
              state_p1 <= ST_ARMED;
              done_p1  <= 1'b0;
            end
          end
          default: begin
            state_p1 <= ST_ARMED;
            done_p1  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign out  = count_p1;
  assign tc   = tc_p1;
  assign done = done_p1;

endmodule : updown_mod_counter
